// File: rtl/alu_pkg.sv
// Shared opcode/funct encodings, FSM state type and captured-request record
// for the shared RV32I ALU arbiter.
package alu_pkg;

  localparam int XLEN_C = 32;

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [XLEN_C-1:0] a;
    logic [XLEN_C-1:0] b;
    logic [4:0]        rd;
    logic              wreg;
  } alu_req_t;

endpackage

// File: rtl/rv_alu.sv
// Combinational RV32I OP / OP-IMM integer ALU; flags any encoding outside
// the supported set and returns zero for it.
module rv_alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            err_o
);

  logic       is_op;
  logic       is_imm;
  logic [4:0] shamt;

  assign is_op  = (opcode_i == OPC_OP);
  assign is_imm = (opcode_i == OPC_OPIMM);
  assign shamt  = b_i[4:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    result_o = '0;
    err_o    = 1'b0;
    if (!is_op && !is_imm) begin
      err_o = 1'b1;
    end else begin
      case (funct3_i)
        F3_ADD: begin
          if (is_imm || funct7_i == F7_BASE) result_o = a_i + b_i;
          else if (funct7_i == F7_ALT)       result_o = a_i - b_i;
          else                               err_o    = 1'b1;
        end
        F3_SLL: begin
          if (funct7_i == F7_BASE) result_o = a_i << shamt;
          else                     err_o    = 1'b1;
        end
        F3_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
        F3_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
        F3_XOR:  result_o = a_i ^ b_i;
        F3_SR: begin
          if (funct7_i == F7_BASE)     result_o = a_i >> shamt;
          else if (funct7_i == F7_ALT) result_o = XLEN'($signed(a_i) >>> shamt);
          else                         err_o    = 1'b1;
        end
        F3_OR:   result_o = a_i | b_i;
        F3_AND:  result_o = a_i & b_i;
        default: err_o    = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one RV32I ALU between the execute slot (req 0) and the
// address-gen/debug port (req 1): accept, evaluate, then hold the result.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [13:0]       req_opcode,
  input  logic [5:0]        req_funct3,
  input  logic [13:0]       req_funct7,
  input  logic [2*XLEN-1:0] req_op_a,
  input  logic [2*XLEN-1:0] req_op_b,
  input  logic [9:0]        req_rd,
  input  logic [1:0]        req_wreg,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_wreg,
  output logic              rsp_err
);

  state_e          state_q, state_d;
  logic            last_grant_q;
  logic            owner_q;
  alu_req_t        req_q;
  alu_req_t        sel_req;
  logic [XLEN-1:0] rsp_data_q;
  logic [4:0]      rsp_rd_q;
  logic            rsp_wreg_q;
  logic            rsp_err_q;

  logic            gnt_idx;
  logic            accept;
  logic [XLEN-1:0] alu_res;
  logic            alu_err;

  // On contention the requester that did not win last time is favoured.
  always_comb begin
    gnt_idx   = req_valid[1];
    req_ready = 2'b00;
    if (req_valid == 2'b11) gnt_idx = ~last_grant_q;
    if (rst_n && state_q == ST_IDLE && req_valid[gnt_idx]) req_ready[gnt_idx] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    sel_req.opcode = gnt_idx ? req_opcode[13:7]          : req_opcode[6:0];
    sel_req.funct3 = gnt_idx ? req_funct3[5:3]           : req_funct3[2:0];
    sel_req.funct7 = gnt_idx ? req_funct7[13:7]          : req_funct7[6:0];
    sel_req.a      = gnt_idx ? req_op_a[2*XLEN-1:XLEN]   : req_op_a[XLEN-1:0];
    sel_req.b      = gnt_idx ? req_op_b[2*XLEN-1:XLEN]   : req_op_b[XLEN-1:0];
    sel_req.rd     = gnt_idx ? req_rd[9:5]               : req_rd[4:0];
    sel_req.wreg   = gnt_idx ? req_wreg[1]               : req_wreg[0];
  end

  always_comb begin
    state_d   = state_q;
    rsp_valid = 2'b00;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid = 2'b01 << owner_q;
        if (rsp_ready[owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  rv_alu #(.XLEN(XLEN)) u_alu (
    .opcode_i (req_q.opcode),
    .funct3_i (req_q.funct3),
    .funct7_i (req_q.funct7),
    .a_i      (req_q.a),
    .b_i      (req_q.b),
    .result_o (alu_res),
    .err_o    (alu_err)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ~RR_INIT;
      owner_q      <= 1'b0;
      rsp_data_q   <= '0;
      rsp_rd_q     <= '0;
      rsp_wreg_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= gnt_idx;
        owner_q      <= gnt_idx;
      end
      if (state_q == ST_EXEC) begin
        rsp_data_q <= alu_res;
        rsp_rd_q   <= req_q.rd;
        rsp_wreg_q <= req_q.wreg & ~alu_err;
        rsp_err_q  <= alu_err;
      end
    end
  end

  // NOTE: operand capture is datapath only and is not reset; it is always written before use.
  always_ff @(posedge clk) begin
    if (accept) req_q <= sel_req;
  end

  assign rsp_data = rsp_data_q;
  assign rsp_rd   = rsp_rd_q;
  assign rsp_wreg = rsp_wreg_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: expected responses are queued at grant
// time and compared when the owner sees rsp_valid.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [13:0] req_opcode;
  logic [5:0]  req_funct3;
  logic [13:0] req_funct7;
  logic [63:0] req_op_a;
  logic [63:0] req_op_b;
  logic [9:0]  req_rd;
  logic [1:0]  req_wreg;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_wreg;
  logic        rsp_err;

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wreg;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  alu_share_arbiter #(.XLEN(32), .RR_INIT(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_funct3 (req_funct3),
    .req_funct7 (req_funct7),
    .req_op_a   (req_op_a),
    .req_op_b   (req_op_b),
    .req_rd     (req_rd),
    .req_wreg   (req_wreg),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_rd     (rsp_rd),
    .rsp_wreg   (rsp_wreg),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_req(input int k, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic wr);
    req_opcode[k*7 +: 7]  = opc;
    req_funct3[k*3 +: 3]  = f3;
    req_funct7[k*7 +: 7]  = f7;
    req_op_a[k*32 +: 32]  = a;
    req_op_b[k*32 +: 32]  = b;
    req_rd[k*5 +: 5]      = rd;
    req_wreg[k]           = wr;
    req_valid[k]          = 1'b1;
  endtask

  task automatic push_exp(input int k, input logic [31:0] data, input logic [4:0] rd,
                          input logic wreg, input logic err);
    exp_t e;
    e.vld  = 2'(1 << k);
    e.data = data;
    e.rd   = rd;
    e.wreg = wreg;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(e.vld));
      chk({tag, "_rsp_data"},  rsp_data,       e.data);
      chk({tag, "_rsp_rd"},    32'(rsp_rd),    32'(e.rd));
      chk({tag, "_rsp_wreg"},  32'(rsp_wreg),  32'(e.wreg));
      chk({tag, "_rsp_err"},   32'(rsp_err),   32'(e.err));
    end
  endtask

  // One isolated transaction: grant, EXEC (no response yet), RESP two cycles later, accept.
  task automatic run_one(input string tag, input int k, input logic [6:0] opc,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic wr,
                         input logic [31:0] exp_data, input logic exp_err);
    @(negedge clk);
    set_req(k, opc, f3, f7, a, b, rd, wr);
    #1;
    chk({tag, "_grant"}, 32'(req_ready), 32'(1 << k));
    push_exp(k, exp_data, rd, wr & ~exp_err, exp_err);
    @(negedge clk);
    req_valid = 2'b00;
    chk({tag, "_exec_quiet"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_rsp(tag);
    rsp_ready = 2'(1 << k);
    @(negedge clk);
    rsp_ready = 2'b00;
    chk({tag, "_released"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 2'b11;
    req_opcode = '0;
    req_funct3 = '0;
    req_funct7 = '0;
    req_op_a   = '0;
    req_op_b   = '0;
    req_rd     = '0;
    req_wreg   = '0;
    rsp_ready  = 2'b00;

    // Reset values, with both requesters valid to show no grant under reset.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  rsp_data,       32'd0);
    chk("rst_rsp_rd",    32'(rsp_rd),    32'd0);
    chk("rst_rsp_wreg",  32'(rsp_wreg),  32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    req_valid = 2'b00;
    rst_n     = 1'b1;

    // Contention from reset: RR_INIT=0 wins first, then strict alternation.
    @(negedge clk);
    set_req(0, OPC_OP,    F3_ADD, F7_BASE, 32'd1,     32'd2,     5'd1, 1'b1);
    set_req(1, OPC_OPIMM, F3_XOR, 7'h00,   32'h000000F0, 32'h000000FF, 5'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = i % 2;
      #1;
      chk($sformatf("rr%0d_grant", i), 32'(req_ready), 32'(1 << k));
      if (k == 0) push_exp(0, 32'd3, 5'd1, 1'b1, 1'b0);
      else        push_exp(1, 32'h0000000F, 5'd2, 1'b1, 1'b0);
      @(negedge clk);
      chk($sformatf("rr%0d_exec_noready", i), 32'(req_ready), 32'd0);
      @(negedge clk);
      check_rsp($sformatf("rr%0d", i));
      chk($sformatf("rr%0d_resp_noready", i), 32'(req_ready), 32'd0);
      rsp_ready = 2'(1 << k);
      @(negedge clk);
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;

    // Main function, shifts, compares and illegal encodings.
    run_one("sub",     0, OPC_OP,    F3_ADD,  F7_ALT,  32'd5,        32'd7, 5'd3,  1'b1, 32'hFFFFFFFE, 1'b0);
    run_one("sra",     1, OPC_OP,    F3_SR,   F7_ALT,  32'h80000000, 32'd4, 5'd4,  1'b1, 32'hF8000000, 1'b0);
    run_one("srl",     0, OPC_OPIMM, F3_SR,   F7_BASE, 32'h80000000, 32'd4, 5'd5,  1'b1, 32'h08000000, 1'b0);
    run_one("slt",     1, OPC_OP,    F3_SLT,  F7_BASE, 32'hFFFFFFFF, 32'd1, 5'd6,  1'b1, 32'd1,        1'b0);
    run_one("sltu",    0, OPC_OP,    F3_SLTU, F7_BASE, 32'hFFFFFFFF, 32'd1, 5'd7,  1'b1, 32'd0,        1'b0);
    run_one("andi_f7", 1, OPC_OPIMM, F3_AND,  7'h55,   32'h0000F0F0, 32'h0000FF00, 5'd8, 1'b1, 32'h0000F000, 1'b0);
    run_one("sll",     0, OPC_OP,    F3_SLL,  F7_BASE, 32'h00000003, 32'd31, 5'd9, 1'b1, 32'h80000000, 1'b0);
    run_one("bad_opc", 0, 7'b0000011, F3_ADD, F7_BASE, 32'd9,        32'd9, 5'd10, 1'b1, 32'd0,        1'b1);
    run_one("bad_sll", 1, OPC_OP,    F3_SLL,  F7_ALT,  32'd1,        32'd1, 5'd11, 1'b1, 32'd0,        1'b1);
    run_one("bad_add", 0, OPC_OP,    F3_ADD,  7'b0000001, 32'd1,     32'd1, 5'd12, 1'b1, 32'd0,        1'b1);

    // Backpressure: result held stable for 5 cycles, no new grant, non-owner ready ignored.
    @(negedge clk);
    set_req(0, OPC_OP, F3_OR, F7_BASE, 32'h000000F0, 32'h0000000F, 5'd13, 1'b1);
    #1;
    chk("bp_grant", 32'(req_ready), 32'd1);
    push_exp(0, 32'h000000FF, 5'd13, 1'b1, 1'b0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    set_req(1, OPC_OPIMM, F3_ADD, 7'h7F, 32'd10, 32'd20, 5'd14, 1'b1);
    #1;
    chk("bp_exec_noready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check_rsp("bp");
    for (int i = 0; i < 5; i++) begin
      rsp_ready = 2'b10;
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp_hold%0d_data", i),  rsp_data,       32'h000000FF);
      chk($sformatf("bp_hold%0d_ready", i), 32'(req_ready), 32'd0);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    chk("bp_released", 32'(rsp_valid), 32'd0);
    chk("bp_idle_grant", 32'(req_ready), 32'd2);
    push_exp(1, 32'd30, 5'd14, 1'b1, 1'b0);
    @(negedge clk);
    req_valid = 2'b00;
    chk("bp2_exec_quiet", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_rsp("bp2");
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;

    // Reset while in EXEC drops the transaction.
    @(negedge clk);
    set_req(0, OPC_OP, F3_ADD, F7_BASE, 32'd100, 32'd1, 5'd15, 1'b1);
    #1;
    chk("rx_grant", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    rst_n     = 1'b0;
    @(negedge clk);
    req_valid = 2'b01;
    #1;
    chk("rx_ready_in_reset", 32'(req_ready), 32'd0);
    chk("rx_valid_in_reset", 32'(rsp_valid), 32'd0);
    req_valid = 2'b00;
    rst_n     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rx_dropped%0d", i), 32'(rsp_valid), 32'd0);
    end
    run_one("after_rst", 1, OPC_OPIMM, F3_ADD, F7_BASE, 32'd41, 32'd1, 5'd16, 1'b1, 32'd42, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
